// File: rtl/key_pkg.sv
// Shared state encoding and default timing constants for the key click classifier.
package key_pkg;

  localparam int unsigned TIMER_W = 26;

  localparam logic [25:0] LONG_MAX = 26'd49_999_999;
  localparam logic [23:0] GAP_MAX  = 24'd14_999_999;
  localparam logic [19:0] REL_MAX  = 20'd999_999;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD1    = 3'd1,
    GAP      = 3'd2,
    HOLD2    = 3'd3,
    WAIT_REL = 3'd4
  } state_e;

endpackage

// File: rtl/key_release_det.sv
// Synchronises the raw active-low key line and flags a release once it has stayed high
// for REL_MAX cycles.
module key_release_det #(
  parameter logic [19:0] REL_MAX = key_pkg::REL_MAX
) (
  input  logic clk_50,
  input  logic rst,
  input  logic key_in,
  output logic rel_pulse
);

  logic        sync1_q, sync2_q;
  logic [19:0] cnt_q, cnt_d;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating at REL_MAX means the pulse fires once per release, never repeatedly.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q < REL_MAX) begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  assign rel_pulse = (cnt_q == (REL_MAX - 20'd1));

endmodule

// File: rtl/key_click_classifier.sv
// Classifies debounced key gestures into single click, double click or long press,
// emitting one registered pulse per gesture.
module key_click_classifier #(
  parameter logic [25:0] LONG_MAX = key_pkg::LONG_MAX,
  parameter logic [23:0] GAP_MAX  = key_pkg::GAP_MAX,
  parameter logic [19:0] REL_MAX  = key_pkg::REL_MAX
) (
  input  logic clk_50,
  input  logic rst,
  input  logic key_flag,
  input  logic key_in,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  import key_pkg::*;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 single_q, single_d;
  logic                 double_q, double_d;
  logic                 long_q, long_d;
  logic                 rel_pulse;
  logic                 long_hit, gap_hit;

  key_release_det #(
    .REL_MAX (REL_MAX)
  ) u_release_det (
    .clk_50    (clk_50),
    .rst       (rst),
    .key_in    (key_in),
    .rel_pulse (rel_pulse)
  );

  assign long_hit = (timer_q == LONG_MAX);
  assign gap_hit  = (timer_q == {2'b00, GAP_MAX});

  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_flag) state_d = HOLD1;
      end
      HOLD1: begin
        // Long press takes priority over a release landing on the same cycle.
        if (long_hit) begin
          long_d  = 1'b1;
          state_d = WAIT_REL;
        end else if (rel_pulse) begin
          state_d = GAP;
        end
      end
      GAP: begin
        // A second press on the timeout cycle still forms a double click.
        if (key_flag) begin
          state_d = HOLD2;
        end else if (gap_hit) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end
      end
      HOLD2: begin
        if (rel_pulse) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      WAIT_REL: begin
        if (rel_pulse) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q + TIMER_W'(1);
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign busy         = (state_q != IDLE);

endmodule
